seq_mult32: RTL and testbench
=============================

# seq_mult32

Unsigned sequential shift-and-add multiplier that sits directly downstream of the 32-bit ripple adder stage and reuses it as its datapath. Each cycle it adds the latched multiplicand into a running accumulator through a `{Cout, Sum} = In1 + In2 + Cin` adder and shifts right one bit. It produces a 2·WIDTH-bit product after WIDTH iterations. It gives the lab ALU its multiply path, using a start/done handshake.

## Interface
- `WIDTH`, 32, operand width in bits; product is 2·WIDTH bits.
- `clk` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `In1` input WIDTH: multiplicand, latched when `start` is accepted.
- `In2` input WIDTH: multiplier, latched when `start` is accepted.
- `busy` output 1: high while iterations are in progress (state RUN).
- `done` output 1: one-cycle pulse; `Product` is valid in that cycle.
- `Product` output 2·WIDTH: result. Held from `done` until the next accepted `start` or `reset`.

## Operation
- Internal registers:
  - M (WIDTH): multiplicand.
  - A (WIDTH): accumulator high half.
  - Q (WIDTH): multiplier, which becomes the low half of the product.
  - C (1): adder carry.
  - cnt (log2(WIDTH)+1 bits): iteration counter.
- States: IDLE, RUN, DONE.
- IDLE:
  - When `start` is sampled 1: M←In1, Q←In2, A←0, C←0, cnt←0, go to RUN.
  - Otherwise stay in IDLE.
- RUN, one iteration per cycle:
  - If Q[0]=1, `{C, A_sum} = A + M` with Cin=0, using a WIDTH+1-bit result. If Q[0]=0, `{C, A_sum} = {0, A}`.
  - Then `{A, Q} ← {C, A_sum, Q} >> 1`, i.e. A←{C, A_sum[WIDTH-1:1]} and Q←{A_sum[0], Q[WIDTH-1:1]}.
  - cnt←cnt+1.
  - When cnt reaches WIDTH-1 during this update, go to DONE and load `Product`←the shifted {A, Q}.
- DONE:
  - `done`=1 for exactly this one cycle, then unconditionally return to IDLE.
  - `start` is ignored in DONE.
- `start` asserted in RUN or DONE is ignored: no queueing and no restart.
- `In1`/`In2` changes after acceptance have no effect on the result.
- Arithmetic is unsigned. The carry out of every add is retained by the shift, so no overflow is possible. The full 2·WIDTH product is exact.
- Reset values: state=IDLE, `busy`=0, `done`=0, `Product`=0, M=A=Q=0, C=0, cnt=0.
- Reset asserted mid-RUN aborts the operation:
  - No `done` pulse is produced.
  - `Product` is forced to 0.
  - `start` in the same cycle as `reset` is ignored; reset wins.

## Timing
- Edge E0: `start` sampled in IDLE; from the cycle after E0, `busy`=1.
- Edges E1..E(WIDTH): perform the WIDTH iterations.
- Cycle after E(WIDTH): `busy`=0, `done`=1, and `Product` is valid. For WIDTH=32, `done` rises 32 cycles after the accepting edge.
- Edge E(WIDTH+1): state returns to IDLE and `done`=0.
  - A `start` held high in the DONE cycle is ignored at that edge.
  - The earliest new acceptance is edge E(WIDTH+2).
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `SEQ_MULT_ZERO_BYPASS_EN`.
- Defined: if `In1`==0 or `In2`==0 when `start` is accepted, skip RUN and go directly to DONE.
  - `Product`=0.
  - `done` is high in the cycle after E0.
  - `busy` never asserts.
- Not defined: zero operands take the full WIDTH iterations like any other operands.

## Test plan
- `In1`=3, `In2`=5, `start` for one cycle → `busy` for 32 cycles, then `done`=1 with `Product`=64'h0000_0000_0000_000F; `done` low in the next cycle.
- `In1`=`In2`=32'hFFFF_FFFF → `Product`=64'hFFFF_FFFE_0000_0001, exercising the carry retained on every iteration.
- `In1`=32'h8585_8585, `In2`=0 → with `SEQ_MULT_ZERO_BYPASS_EN` defined: `done` in the cycle after the accepting edge, `Product`=0, `busy` never high. Without the macro: `done` after 32 cycles, `Product`=0.
- Accept 7×9, then pulse `start` with `In1`=2, `In2`=2 at cycle 10 of RUN and again during DONE → both ignored; result `Product`=63 at the normal time.
- `reset` at cycle 16 of RUN on 100×100 → next cycle `busy`=0, `done`=0, `Product`=0, and no `done` pulse follows. A subsequent `start` of 100×100 yields 10000 after 32 cycles.
- Back-to-back: `start` held continuously with `In1`=6, `In2`=7 → `Product`=42 at each `done`. `done` pulses are WIDTH+2 cycles apart.

Source files
------------

// File: rtl/seq_mult32_if.sv
// rtl/seq_mult32_if.sv - start/done handshake and operand/result bus for seq_mult32
interface seq_mult32_if #(
   parameter int WIDTH = 32
);
   logic               start;
   logic [WIDTH-1:0]   In1;
   logic [WIDTH-1:0]   In2;
   logic               busy;
   logic               done;
   logic [2*WIDTH-1:0] Product;

   modport master (
      output start, In1, In2,
      input  busy, done, Product
   );

   modport slave (
      input  start, In1, In2,
      output busy, done, Product
   );
endinterface

// File: rtl/seq_mult32.sv
// rtl/seq_mult32.sv - unsigned shift-and-add multiplier, one iteration per clock
// Optional SEQ_MULT_ZERO_BYPASS_EN: zero operands skip RUN and report Product=0 at once.
module seq_mult32 #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   seq_mult32_if.slave  bus
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   m, a, q;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH:0]     sum;
   logic               c;
   logic               last;
   logic               zero_op;

   // Adder result is WIDTH+1 bits so the carry survives into the shift
   assign sum  = q[0] ? ({1'b0, a} + {1'b0, m}) : {1'b0, a};
   assign c    = sum[WIDTH];
   assign last = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_ZERO_BYPASS_EN
   assign zero_op = (bus.In1 == '0) || (bus.In2 == '0);
`else
   assign zero_op = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = zero_op ? DONE : RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      case (state)
         RUN:     bus.busy = 1'b1;
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         m       <= '0;
         a       <= '0;
         q       <= '0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  m   <= bus.In1;
                  q   <= bus.In2;
                  a   <= '0;
                  cnt <= '0;
                  if (zero_op) product <= '0;
               end
            end
            RUN: begin
               a   <= {c, sum[WIDTH-1:1]};
               q   <= {sum[0], q[WIDTH-1:1]};
               cnt <= cnt + 1'b1;
               // Final iteration: capture the shifted {A,Q} directly as the result
               if (last) product <= {c, sum, q[WIDTH-1:1]};
            end
            default: ;
         endcase
      end
   end

   assign bus.Product = product;
endmodule

// File: tb/tb_seq_mult32.sv
// tb/tb_seq_mult32.sv - randomized self-checking bench for seq_mult32
module tb_seq_mult32;
   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   seq_mult32_if #(.WIDTH(32)) bus ();

   seq_mult32 #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
      return {32'b0, x} * {32'b0, y};
   endfunction

   function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
`ifdef SEQ_MULT_ZERO_BYPASS_EN
      if (x == 0 || y == 0) return 0;
`endif
      return 32;
   endfunction

   // Accept one operation, wait (bounded) for done; lat counts edges after the accepting edge
   task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                         output int lat, output int busy_n, output logic [63:0] p);
      bus.In1   = x;
      bus.In2   = y;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      bus.In1   = $urandom;
      bus.In2   = $urandom;
      lat = 0;
      busy_n = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (bus.busy === 1'b1) busy_n++;
         cyc();
         lat++;
      end
      p = bus.Product;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.start = 1'b0;
      bus.In1 = '0;
      bus.In2 = '0;
      repeat (3) cyc();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Product !== 64'd0) begin
         errors++;
         $display("FAIL reset_state busy=%b done=%b product=%h expected 0 0 0", bus.busy, bus.done, bus.Product);
      end
      reset = 1'b0;
      cyc();
   endtask

   task automatic test_basic();
      int lat, bn;
      logic [63:0] p;
      run_op(32'd3, 32'd5, lat, bn, p);
      checks++;
      if (p !== 64'h0000_0000_0000_000F || lat != 32 || bn != 32) begin
         errors++;
         $display("FAIL basic_3x5 product=%h lat=%0d busy=%0d expected 000000000000000f 32 32", p, lat, bn);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_busy_in_done busy=%b expected 0", bus.busy);
      end
      cyc();
      checks++;
      if (bus.done !== 1'b0 || bus.Product !== 64'hF) begin
         errors++;
         $display("FAIL basic_done_pulse done=%b product=%h expected 0 f", bus.done, bus.Product);
      end
   endtask

   task automatic test_all_ones();
      int lat, bn;
      logic [63:0] p;
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bn, p);
      checks++;
      if (p !== 64'hFFFF_FFFE_0000_0001 || lat != 32) begin
         errors++;
         $display("FAIL all_ones product=%h lat=%0d expected fffffffe00000001 32", p, lat);
      end
      cyc();
   endtask

   task automatic test_zero();
      int lat, bn;
      logic [63:0] p;
      run_op(32'h8585_8585, 32'd0, lat, bn, p);
      checks++;
      if (p !== 64'd0 || lat != ref_lat(32'h8585_8585, 32'd0) || bn != ref_lat(32'h8585_8585, 32'd0)) begin
         errors++;
         $display("FAIL zero_operand product=%h lat=%0d busy=%0d expected 0 %0d %0d",
                  p, lat, bn, ref_lat(32'h8585_8585, 32'd0), ref_lat(32'h8585_8585, 32'd0));
      end
      cyc();
   endtask

   task automatic test_ignore_start();
      int lat;
      bus.In1 = 32'd7;
      bus.In2 = 32'd9;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      lat = 0;
      while (bus.done !== 1'b1 && lat < 100) begin
         if (lat == 10) begin
            bus.start = 1'b1;
            bus.In1 = 32'd2;
            bus.In2 = 32'd2;
         end else begin
            bus.start = 1'b0;
         end
         cyc();
         lat++;
      end
      checks++;
      if (bus.Product !== 64'd63 || lat != 32) begin
         errors++;
         $display("FAIL ignore_start_run product=%h lat=%0d expected 3f 32", bus.Product, lat);
      end
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.Product !== 64'd63) begin
         errors++;
         $display("FAIL ignore_start_done done=%b busy=%b product=%h expected 0 0 3f", bus.done, bus.busy, bus.Product);
      end
      cyc();
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start_idle busy=%b done=%b expected 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_reset_abort();
      int lat, bn, seen;
      logic [63:0] p;
      bus.In1 = 32'd100;
      bus.In2 = 32'd100;
      bus.start = 1'b1;
      cyc();
      bus.start = 1'b0;
      repeat (15) cyc();
      reset = 1'b1;
      bus.start = 1'b1;
      cyc();
      reset = 1'b0;
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.Product !== 64'd0) begin
         errors++;
         $display("FAIL reset_abort busy=%b done=%b product=%h expected 0 0 0", bus.busy, bus.done, bus.Product);
      end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_no_done activity_cycles=%0d expected 0", seen);
      end
      run_op(32'd100, 32'd100, lat, bn, p);
      checks++;
      if (p !== 64'd10000 || lat != 32) begin
         errors++;
         $display("FAIL after_reset product=%0d lat=%0d expected 10000 32", p, lat);
      end
      cyc();
   endtask

   task automatic test_back_to_back();
      int t, n, prev;
      bus.In1 = 32'd6;
      bus.In2 = 32'd7;
      bus.start = 1'b1;
      t = 0;
      n = 0;
      prev = -1;
      while (n < 3 && t < 200) begin
         cyc();
         t++;
         if (bus.done === 1'b1) begin
            checks++;
            if (bus.Product !== 64'd42) begin
               errors++;
               $display("FAIL b2b_product pulse=%0d product=%0d expected 42", n, bus.Product);
            end
            if (prev >= 0) begin
               checks++;
               if (t - prev != 34) begin
                  errors++;
                  $display("FAIL b2b_spacing got=%0d expected 34", t - prev);
               end
            end
            prev = t;
            n++;
         end
      end
      bus.start = 1'b0;
      checks++;
      if (n != 3) begin
         errors++;
         $display("FAIL b2b_pulses got=%0d expected 3", n);
      end
      repeat (3) cyc();
   endtask

   task automatic test_random();
      int lat, bn;
      logic [63:0] p;
      logic [31:0] x, y;
      for (int i = 0; i < 8; i++) begin
         x = $urandom;
         y = $urandom;
         if (i == 6) x = 32'd0;
         if (i == 7) y = 32'h0000_0001;
         run_op(x, y, lat, bn, p);
         checks++;
         if (p !== ref_mul(x, y) || lat != ref_lat(x, y)) begin
            errors++;
            $display("FAIL random_%0d %h*%h product=%h lat=%0d expected %h %0d",
                     i, x, y, p, lat, ref_mul(x, y), ref_lat(x, y));
         end
         cyc();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_all_ones();
      test_zero();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
